// File: rtl/perf_counter_sampler.sv
// Sweeps the hpm counters over the shared CSR counter port on a timer tick or trigger,
// optionally clears each one, and streams every 64-bit value out as one sample.
module perf_counter_sampler #(
  parameter int NumCounters = 6,
  parameter int XLEN        = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  input  logic [31:0]     period_i,
  input  logic            trigger_i,
  input  logic            clear_on_read_i,
  output logic            perf_req_o,
  input  logic            perf_gnt_i,
  output logic [11:0]     perf_addr_o,
  output logic            perf_we_o,
  output logic [XLEN-1:0] perf_wdata_o,
  input  logic [XLEN-1:0] perf_rdata_i,
  output logic            sample_valid_o,
  input  logic            sample_ready_i,
  output logic [2:0]      sample_idx_o,
  output logic [63:0]     sample_data_o,
  output logic            busy_o,
  output logic            overrun_o
);
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CLR_LO, CLR_HI, PUSH} state_e;

  localparam logic [2:0] LastIdx = 3'(NumCounters - 1);

  state_e      state_q;
  logic [2:0]  idx_q;
  logic [63:0] sample_q;
  logic        clr_q, overrun_q;
  logic [31:0] timer_q, timer_d;
  logic        tick, start_req, hi_half;

  // A period lowered below the running count wraps the timer without a tick.
  always_comb begin
    tick    = 1'b0;
    timer_d = timer_q + 32'd1;
    if (!enable_i || period_i == 32'd0) begin
      timer_d = 32'd0;
    end else if (timer_q == period_i - 32'd1) begin
      tick    = 1'b1;
      timer_d = 32'd0;
    end else if (timer_q > period_i - 32'd1) begin
      timer_d = 32'd0;
    end
  end

  assign start_req = enable_i && (tick || trigger_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      sample_q  <= 64'd0;
      clr_q     <= 1'b0;
      overrun_q <= 1'b0;
      timer_q   <= 32'd0;
    end else begin
      timer_q   <= timer_d;
      overrun_q <= start_req && (state_q != IDLE);
      case (state_q)
        IDLE: if (start_req) begin
          clr_q   <= clear_on_read_i;
          state_q <= RD_LO;
        end
        RD_LO: if (perf_gnt_i) begin
          sample_q[XLEN-1:0] <= perf_rdata_i;
          if (XLEN == 32) state_q <= RD_HI;
          else            state_q <= clr_q ? CLR_LO : PUSH;
        end
        RD_HI: if (perf_gnt_i) begin
          sample_q[63:32] <= perf_rdata_i[31:0];
          state_q         <= clr_q ? CLR_LO : PUSH;
        end
        CLR_LO: if (perf_gnt_i) state_q <= (XLEN == 32) ? CLR_HI : PUSH;
        CLR_HI: if (perf_gnt_i) state_q <= PUSH;
        PUSH: if (sample_ready_i) begin
          if (idx_q == LastIdx) begin
            idx_q   <= 3'd0;
            state_q <= IDLE;
          end else begin
            idx_q   <= idx_q + 3'd1;
            state_q <= RD_LO;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign perf_req_o     = (state_q == RD_LO) || (state_q == RD_HI) ||
                          (state_q == CLR_LO) || (state_q == CLR_HI);
  assign hi_half        = (state_q == RD_HI) || (state_q == CLR_HI);
  assign perf_addr_o    = !perf_req_o ? 12'd0 :
                          (hi_half ? 12'hB83 : 12'hB03) + {9'd0, idx_q};
  assign perf_we_o      = (state_q == CLR_LO) || (state_q == CLR_HI);
  assign perf_wdata_o   = '0;
  assign sample_valid_o = (state_q == PUSH);
  assign sample_idx_o   = idx_q;
  assign sample_data_o  = sample_q;
  assign busy_o         = (state_q != IDLE);
  assign overrun_o      = overrun_q;
endmodule

// File: tb/tb_perf_counter_sampler.sv
// Scoreboard bench: a 64-bit and a 32-bit sampler against behavioural counter files.
module tb_perf_counter_sampler;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        en, trig, clr, gnt, rdy, trig3, clr3;
  logic [31:0] period;
  logic        req, we, valid, busy, ovr;
  logic [11:0] addr;
  logic [63:0] wdata, rdata, sdata;
  logic [2:0]  sidx;
  logic        req3, we3, valid3, busy3, ovr3;
  logic [11:0] addr3;
  logic [31:0] wdata3, rdata3;
  logic [63:0] sdata3;
  logic [2:0]  sidx3;

  perf_counter_sampler #(.NumCounters(6), .XLEN(64)) u64 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .period_i(period), .trigger_i(trig),
    .clear_on_read_i(clr), .perf_req_o(req), .perf_gnt_i(gnt), .perf_addr_o(addr),
    .perf_we_o(we), .perf_wdata_o(wdata), .perf_rdata_i(rdata), .sample_valid_o(valid),
    .sample_ready_i(rdy), .sample_idx_o(sidx), .sample_data_o(sdata), .busy_o(busy),
    .overrun_o(ovr));

  perf_counter_sampler #(.NumCounters(6), .XLEN(32)) u32 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .period_i(32'd0), .trigger_i(trig3),
    .clear_on_read_i(clr3), .perf_req_o(req3), .perf_gnt_i(1'b1), .perf_addr_o(addr3),
    .perf_we_o(we3), .perf_wdata_o(wdata3), .perf_rdata_i(rdata3), .sample_valid_o(valid3),
    .sample_ready_i(1'b1), .sample_idx_o(sidx3), .sample_data_o(sdata3), .busy_o(busy3),
    .overrun_o(ovr3));

  // Behavioural counter files: combinational read, clear on granted write.
  logic [63:0] cnt [6], cnt3 [6], init [6];
  logic        load, load3;
  wire  [11:0] off  = addr - 12'hB03;
  wire  [11:0] lo3  = addr3 - 12'hB03;
  wire  [11:0] hi3  = addr3 - 12'hB83;
  assign rdata  = (off < 12'd6) ? cnt[off[2:0]] : 64'd0;
  assign rdata3 = (lo3 < 12'd6) ? cnt3[lo3[2:0]][31:0] :
                  (hi3 < 12'd6) ? cnt3[hi3[2:0]][63:32] : 32'd0;

  always @(posedge clk) begin
    if (load) for (int i = 0; i < 6; i++) cnt[i] <= init[i];
    else if (req && gnt && we && off < 12'd6) cnt[off[2:0]] <= 64'd0;
  end
  always @(posedge clk) begin
    if (load3) for (int i = 0; i < 6; i++) cnt3[i] <= init[i];
    else if (req3 && we3) begin
      if (lo3 < 12'd6) cnt3[lo3[2:0]][31:0] <= 32'd0;
      else if (hi3 < 12'd6) cnt3[hi3[2:0]][63:32] <= 32'd0;
    end
  end

  typedef struct packed { logic [2:0] idx; logic [63:0] data; } samp_t;
  typedef struct packed { logic [11:0] addr; logic we; } acc_t;
  samp_t q64[$], q32[$];
  acc_t  a64[$], a32[$];
  bit    acc_en;
  int    seen64 = 0;
  int    n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got unexpected event, expected none", name);
  endtask

  // Monitor: pops expectations whenever the DUT completes a handshake or port access.
  always @(negedge clk) begin
    samp_t s;
    acc_t  a;
    if (rst_n) begin
      if (valid && rdy) begin
        seen64++;
        if (q64.size() == 0) flag("s64_extra");
        else begin
          s = q64.pop_front();
          chk("s64_idx", 64'(sidx), 64'(s.idx));
          chk("s64_data", sdata, s.data);
        end
      end
      if (acc_en && req && gnt) begin
        if (a64.size() == 0) flag("a64_extra");
        else begin
          a = a64.pop_front();
          chk("a64_addr", 64'(addr), 64'(a.addr));
          chk("a64_we", 64'(we), 64'(a.we));
          if (we) chk("a64_wdata", wdata, 64'd0);
        end
      end
      if (valid3) begin
        if (q32.size() == 0) flag("s32_extra");
        else begin
          s = q32.pop_front();
          chk("s32_idx", 64'(sidx3), 64'(s.idx));
          chk("s32_data", sdata3, s.data);
        end
      end
      if (req3) begin
        if (a32.size() == 0) flag("a32_extra");
        else begin
          a = a32.pop_front();
          chk("a32_addr", 64'(addr3), 64'(a.addr));
          chk("a32_we", 64'(we3), 64'(a.we));
          if (we3) chk("a32_wdata", 64'(wdata3), 64'd0);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 6; i++) init[i] = 64'((i + 1) * 10);
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic push_samples();
    for (int i = 0; i < 6; i++) q64.push_back('{idx: 3'(i), data: 64'((i + 1) * 10)});
  endtask

  task automatic pulse();
    trig = 1'b1;
    cyc();
    trig = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 300 && busy; k++) cyc();
    if (busy) flag(name);
  endtask

  initial begin
    int bc, ovc, bad, base, k, held;
    en = 0; trig = 0; clr = 0; gnt = 1; rdy = 1; period = 0;
    trig3 = 0; clr3 = 0; load = 0; load3 = 0; acc_en = 0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_valid", 64'(valid), 0);
    chk("rst_req", 64'(req), 0);
    chk("rst_addr", 64'(addr), 0);
    chk("rst_we", 64'(we), 0);
    chk("rst_ovr", 64'(ovr), 0);
    chk("rst_data", sdata, 0);
    chk("rst_idx", 64'(sidx), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    en = 1'b1;
    cyc();

    // Plain sweep: six reads, six samples, 12 busy cycles.
    preload();
    acc_en = 1'b1;
    for (int i = 0; i < 6; i++) a64.push_back('{addr: 12'hB03 + 12'(i), we: 1'b0});
    push_samples();
    pulse();
    bc = 0;
    for (k = 0; k < 100 && busy; k++) begin bc++; cyc(); end
    chk("t1_busy_cycles", 64'(bc), 12);
    chk("t1_samples_left", 64'(q64.size()), 0);
    chk("t1_access_left", 64'(a64.size()), 0);

    // Clear-on-read: read then write zero at the same address.
    preload();
    clr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a64.push_back('{addr: 12'hB03 + 12'(i), we: 1'b0});
      a64.push_back('{addr: 12'hB03 + 12'(i), we: 1'b1});
    end
    push_samples();
    pulse();
    clr = 1'b0;
    wait_idle("t2_timeout");
    for (int i = 0; i < 6; i++) chk("t2_cleared", cnt[i], 0);
    chk("t2_samples_left", 64'(q64.size()), 0);
    chk("t2_access_left", 64'(a64.size()), 0);

    // 32-bit port: lo rd, hi rd, lo wr, hi wr per counter.
    for (int i = 0; i < 6; i++) init[i] = {32'(i + 1), 32'(i * 3 + 5)};
    load3 = 1'b1;
    cyc();
    load3 = 1'b0;
    clr3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a32.push_back('{addr: 12'hB03 + 12'(i), we: 1'b0});
      a32.push_back('{addr: 12'hB83 + 12'(i), we: 1'b0});
      a32.push_back('{addr: 12'hB03 + 12'(i), we: 1'b1});
      a32.push_back('{addr: 12'hB83 + 12'(i), we: 1'b1});
      q32.push_back('{idx: 3'(i), data: {32'(i + 1), 32'(i * 3 + 5)}});
    end
    chk("t3_counter3", q32[0].data, 64'h0000_0001_0000_0005);
    trig3 = 1'b1;
    cyc();
    trig3 = 1'b0;
    clr3 = 1'b0;
    for (k = 0; k < 300 && busy3; k++) cyc();
    if (busy3) flag("t3_timeout");
    for (int i = 0; i < 6; i++) chk("t3_cleared", cnt3[i], 0);
    chk("t3_samples_left", 64'(q32.size()), 0);
    chk("t3_access_left", 64'(a32.size()), 0);

    // Grant withheld for 3 cycles on idx 2 read.
    preload();
    for (int i = 0; i < 6; i++) a64.push_back('{addr: 12'hB03 + 12'(i), we: 1'b0});
    push_samples();
    pulse();
    for (k = 0; k < 50 && !(req && addr == 12'hB05); k++) cyc();
    if (!(req && addr == 12'hB05)) flag("t4_no_b05");
    gnt = 1'b0;
    held = 1;
    for (int j = 0; j < 3; j++) begin
      cyc();
      if (req && addr == 12'hB05) held++;
      if (j == 2) gnt = 1'b1;
    end
    chk("t4_addr_hold", 64'(held), 4);
    cyc();
    chk("t4_advanced", 64'(addr == 12'hB05), 0);
    wait_idle("t4_timeout");
    chk("t4_samples_left", 64'(q64.size()), 0);
    chk("t4_access_left", 64'(a64.size()), 0);
    acc_en = 1'b0;

    // Periodic sweep stalled in PUSH; second tick overruns once.
    preload();
    rdy = 1'b0;
    push_samples();
    base = seen64;
    period = 32'd20;
    for (k = 0; k < 100 && !valid; k++) cyc();
    if (!valid) flag("t5_no_valid");
    ovc = 0; bad = 0;
    repeat (30) begin
      cyc();
      if (ovr) ovc++;
      if (!(valid && sidx == 3'd0)) bad++;
    end
    chk("t5_overrun_count", 64'(ovc), 1);
    chk("t5_stall_unstable", 64'(bad), 0);
    period = 32'd0;
    rdy = 1'b1;
    wait_idle("t5_timeout");
    chk("t5_sample_count", 64'(seen64 - base), 6);
    chk("t5_samples_left", 64'(q64.size()), 0);

    // Reset during PUSH of idx 3.
    preload();
    for (int i = 0; i < 3; i++) q64.push_back('{idx: 3'(i), data: 64'((i + 1) * 10)});
    pulse();
    for (k = 0; k < 50 && !(req && addr == 12'hB06); k++) cyc();
    rdy = 1'b0;
    for (k = 0; k < 10 && !valid; k++) cyc();
    chk("t6_push_idx", 64'(sidx), 3);
    chk("t6_pre_samples", 64'(q64.size()), 0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(valid), 0);
    chk("t6_rst_busy", 64'(busy), 0);
    chk("t6_rst_idx", 64'(sidx), 0);
    cyc();
    rst_n = 1'b1;
    q64.delete();
    push_samples();
    rdy = 1'b1;
    cyc();
    pulse();
    wait_idle("t6_timeout");
    chk("t6_samples_left", 64'(q64.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/perf_counter_sampler.md
Name: perf_counter_sampler

Overview:
- Initiator on the SRAM-like CSR port of the hardware performance counters (mhpmcounter3..8). It is the master side of the addr/we/wdata/rdata interface that the CSR file normally drives.
- On a periodic timer tick or an external trigger, it sweeps all counters and reads each value, then optionally clears it. Each value is emitted as one sample on a valid/ready stream toward the trace/debug buffer.
- It shares the counter port with the CSR file through a same-cycle request/grant.

Parameters:
- NumCounters, 6, number of generic counters swept; index 0 maps to mhpmcounter3.
- XLEN, riscv::XLEN, data width of the counter port; 32 means each counter is accessed as low half plus high half.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- enable_i  in  1  enables the timer and trigger acceptance
- period_i  in  32  cycles between periodic sweeps; 0 disables the timer
- trigger_i  in  1  single-cycle request for an immediate sweep
- clear_on_read_i  in  1  zero each counter after it is read; sampled at sweep start
- perf_req_o  out  1  sampler drives the counter port this cycle
- perf_gnt_i  in  1  same-cycle grant; the CSR file is not accessing the port
- perf_addr_o  out  12  CSR address
- perf_we_o  out  1  write enable
- perf_wdata_o  out  XLEN  write data; always 0
- perf_rdata_i  in  XLEN  combinational read data for perf_addr_o
- sample_valid_o  out  1  sample available
- sample_ready_i  in  1  consumer accepts
- sample_idx_o  out  3  counter index 0..NumCounters-1
- sample_data_o  out  64  full 64-bit counter value; zero-extended when XLEN=64 is not applicable
- busy_o  out  1  sweep in progress (state != IDLE)
- overrun_o  out  1  one-cycle pulse: a sweep request was dropped

Behaviour:
- Reset: state IDLE, timer 0, idx 0, sample register 0. All outputs are 0.
- FSM states: IDLE, RD_LO, RD_HI, CLR_LO, CLR_HI, PUSH.
  - RD_HI and CLR_HI are visited only when XLEN==32.
- Addresses:
  - Low half / full value: CSR_MHPM_COUNTER_3 + idx (0xB03 + idx).
  - High half: CSR_MHPM_COUNTER_3H + idx (0xB83 + idx).
- Port outputs: in RD_* and CLR_*, perf_req_o=1. A state advances only in a cycle where perf_gnt_i=1; otherwise it holds with the address stable.
  - Outside those states, perf_req_o, perf_addr_o and perf_we_o are 0.
- Reads: RD_LO captures perf_rdata_i into sample[XLEN-1:0] on the granted cycle. RD_HI captures sample[63:32].
  - XLEN=32 only: a carry can occur between the LO and HI reads. This is accepted and no re-read is performed.
- Clears: in CLR_*, perf_we_o=1 and perf_wdata_o=0. CLR_* is skipped when the latched clear flag is 0.
- PUSH:
  - sample_valid_o=1, with sample_idx_o=idx and sample_data_o=sample held stable until sample_ready_i.
  - On the handshake: if idx==NumCounters-1, go to IDLE and set idx=0; else increment idx and go to RD_LO.
  - No combinational path exists from sample_ready_i to sample_valid_o.
- Timer:
  - Counts up while enable_i=1 and period_i!=0.
  - On reaching period_i-1 it raises a tick and wraps to 0.
  - Cleared to 0 when enable_i=0 or period_i=0.
  - If period_i is changed mid-count below the current timer value, the timer wraps to 0 next cycle with no tick.
- Sweep start: in IDLE, when enable_i && (tick || trigger_i), the block latches clear_on_read_i and goes to RD_LO next cycle.
  - A simultaneous tick and trigger start one sweep, with no overrun.
- Overrun: when a tick or trigger arrives while busy_o=1 and enable_i=1, overrun_o pulses for 1 cycle and the request is dropped. Requests are never queued.
- Deasserting enable_i mid-sweep does not abort the sweep; the current sweep completes.
- An asynchronous reset mid-sweep returns to IDLE immediately and drops any pending sample.
  - A partially issued XLEN=32 clear may leave the high half nonzero; this is acceptable.
- Latency: with XLEN=64, constant grant, no clear and ready always 1, each counter takes 2 cycles (RD_LO, PUSH). A full sweep occupies 12 cycles after the start cycle.

Test Plan:
- XLEN=64, counters preloaded 10,20,..,60, trigger_i pulse, gnt=1, ready=1, clear=0 -> 6 samples with idx 0..5 and data 10..60; addresses 0xB03..0xB08; no writes; busy_o high for exactly 12 cycles.
- Same setup with clear=1 -> each read is followed by a write of 0 to the same address; all counters read 0 after the sweep; the samples still carry 10..60.
- XLEN=32, counter3=0x1_0000_0005, clear=1 -> access order 0xB03 rd, 0xB83 rd, 0xB03 wr, 0xB83 wr; the sample carries 0x0000_0001_0000_0005.
- gnt=0 for 3 cycles during RD_LO of idx 2 -> address 0xB05 is held for 4 cycles with perf_req_o=1; only one capture occurs; the sample value is correct.
- period_i=20 with sample_ready_i held 0 for 30 cycles -> the sweep stalls in PUSH with idx 0 stable; the next tick pulses overrun_o once; after ready is released, exactly 6 samples are emitted.
- Reset asserted during PUSH of idx 3 -> valid drops immediately and state returns to IDLE; the next trigger emits idx 0 first.
